// File: rtl/spi_host_byte_select.sv
// TX byte selector for the SPI host: holds one 32-bit word with its byte enables
// and emits the enabled bytes one per cycle, refilling back-to-back with no bubble.
module spi_host_byte_select #(
  parameter int ByteOrder = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] word_i,
  input  logic [3:0]  word_be_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        byte_last_o,
  input  logic        byte_ready_i,
  input  logic        sw_rst_i
);

  logic [31:0] word_q;
  logic [3:0]  be_q;
  logic [1:0]  lane_idx;
  logic [3:0]  lane_oh;
  logic        be_nonzero;
  logic        be_single;
  logic        byte_fire;
  logic        word_fire;

  // Little-endian scans down so the lowest set bit wins; big-endian scans up so the highest wins.
  always_comb begin
    lane_idx = 2'd0;
    if (ByteOrder == 0) begin
      for (int k = 3; k >= 0; k--) begin
        if (be_q[k]) lane_idx = k[1:0];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) lane_idx = k[1:0];
      end
    end
  end

  assign lane_oh    = 4'b0001 << lane_idx;
  assign be_nonzero = (be_q != 4'b0000);
  assign be_single  = be_nonzero && ((be_q & (be_q - 4'd1)) == 4'b0000);

  assign byte_o       = be_nonzero ? word_q[{lane_idx, 3'b000} +: 8] : 8'h00;
  assign byte_valid_o = be_nonzero & ~sw_rst_i;
  assign byte_last_o  = byte_valid_o & be_single;
  assign byte_fire    = byte_valid_o & byte_ready_i;

  // Refill is allowed in the cycle the last byte leaves, giving gapless word-to-word streaming.
  assign word_ready_o = ~sw_rst_i & (~be_nonzero | (byte_fire & byte_last_o));
  assign word_fire    = word_valid_i & word_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || sw_rst_i) begin
      word_q <= 32'h0;
      be_q   <= 4'b0000;
    end else if (word_fire) begin
      word_q <= word_i;
      be_q   <= word_be_i;
    end else if (byte_fire) begin
      be_q   <= be_q & ~lane_oh;
    end
  end

endmodule

// File: tb/tb_spi_host_byte_select.sv
// Bench for spi_host_byte_select: a little-endian and a big-endian instance share stimulus;
// per-cycle vector table plus hand-written stall and reset sequences.
module tb_spi_host_byte_select;

  logic        clk;
  logic        rst_n;
  logic [31:0] word;
  logic [3:0]  word_be;
  logic        word_valid;
  logic        byte_ready;
  logic        sw_rst;

  logic        word_ready_le, word_ready_be;
  logic [7:0]  byte_le, byte_be;
  logic        byte_valid_le, byte_valid_be;
  logic        byte_last_le, byte_last_be;

  int n_checks = 0;
  int n_fail   = 0;

  spi_host_byte_select #(.ByteOrder(0)) dut_le (
    .clk_i(clk), .rst_ni(rst_n), .word_i(word), .word_be_i(word_be),
    .word_valid_i(word_valid), .word_ready_o(word_ready_le), .byte_o(byte_le),
    .byte_valid_o(byte_valid_le), .byte_last_o(byte_last_le),
    .byte_ready_i(byte_ready), .sw_rst_i(sw_rst)
  );

  spi_host_byte_select #(.ByteOrder(1)) dut_be (
    .clk_i(clk), .rst_ni(rst_n), .word_i(word), .word_be_i(word_be),
    .word_valid_i(word_valid), .word_ready_o(word_ready_be), .byte_o(byte_be),
    .byte_valid_o(byte_valid_be), .byte_last_o(byte_last_be),
    .byte_ready_i(byte_ready), .sw_rst_i(sw_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        sw;
    logic        wv;
    logic [31:0] w;
    logic [3:0]  be;
    logic        br;
    logic        bv;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        bl;
    logic        wr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic wv, logic [31:0] w, logic [3:0] be, logic br,
                              logic bv, logic [7:0] b0, logic [7:0] b1, logic bl, logic wr);
    vec_t v;
    v.rstn = 1'b1; v.sw = 1'b0; v.wv = wv; v.w = w; v.be = be; v.br = br;
    v.bv = bv; v.b0 = b0; v.b1 = b1; v.bl = bl; v.wr = wr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rstn, input logic sw, input logic wv,
                       input logic [31:0] w, input logic [3:0] be, input logic br);
    rst_n = rstn; sw_rst = sw; word_valid = wv; word = w; word_be = be; byte_ready = br;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Checks both instances; byte ordering differs, valid/last/ready timing must not.
  task automatic expect_out(input string tag, input logic bv, input logic [7:0] b0,
                            input logic [7:0] b1, input logic bl, input logic wr);
    chk({tag, ".valid_le"}, {31'd0, byte_valid_le}, {31'd0, bv});
    chk({tag, ".valid_be"}, {31'd0, byte_valid_be}, {31'd0, bv});
    chk({tag, ".byte_le"},  {24'd0, byte_le},       {24'd0, b0});
    chk({tag, ".byte_be"},  {24'd0, byte_be},       {24'd0, b1});
    chk({tag, ".last_le"},  {31'd0, byte_last_le},  {31'd0, bl});
    chk({tag, ".last_be"},  {31'd0, byte_last_be},  {31'd0, bl});
    chk({tag, ".wready_le"},{31'd0, word_ready_le}, {31'd0, wr});
    chk({tag, ".wready_be"},{31'd0, word_ready_be}, {31'd0, wr});
  endtask

  initial begin
    // Full word, both orders
    add(0, 32'h0,        4'h0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(1, 32'hDDCCBBAA, 4'hF, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        4'h0, 1, 1, 8'hAA, 8'hDD, 0, 0);
    add(0, 32'h0,        4'h0, 1, 1, 8'hBB, 8'hCC, 0, 0);
    add(0, 32'h0,        4'h0, 1, 1, 8'hCC, 8'hBB, 0, 0);
    add(0, 32'h0,        4'h0, 1, 1, 8'hDD, 8'hAA, 1, 1);
    add(0, 32'h0,        4'h0, 1, 0, 8'h00, 8'h00, 0, 1);
    // Non-contiguous enables
    add(1, 32'hDDCCBBAA, 4'h5, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        4'h0, 1, 1, 8'hAA, 8'hCC, 0, 0);
    add(0, 32'h0,        4'h0, 1, 1, 8'hCC, 8'hAA, 1, 1);
    // Back-to-back words with valid held
    add(1, 32'h44332211, 4'hF, 1, 0, 8'h00, 8'h00, 0, 1);
    add(1, 32'h88776655, 4'h3, 1, 1, 8'h11, 8'h44, 0, 0);
    add(1, 32'h88776655, 4'h3, 1, 1, 8'h22, 8'h33, 0, 0);
    add(1, 32'h88776655, 4'h3, 1, 1, 8'h33, 8'h22, 0, 0);
    add(1, 32'h88776655, 4'h3, 1, 1, 8'h44, 8'h11, 1, 1);
    add(0, 32'h0,        4'h0, 1, 1, 8'h55, 8'h66, 0, 0);
    add(0, 32'h0,        4'h0, 1, 1, 8'h66, 8'h55, 1, 1);
    // Empty enable mask, then a single-byte word
    add(1, 32'h12345678, 4'h0, 1, 0, 8'h00, 8'h00, 0, 1);
    add(1, 32'h000000EE, 4'h1, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        4'h0, 1, 1, 8'hEE, 8'hEE, 1, 1);
    add(0, 32'h0,        4'h0, 1, 0, 8'h00, 8'h00, 0, 1);

    drive(0, 0, 0, 32'h0, 4'h0, 0);
    advance();
    advance();
    expect_out("reset", 0, 8'h00, 8'h00, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].sw, vecs[i].wv, vecs[i].w, vecs[i].be, vecs[i].br);
      expect_out($sformatf("vec%0d", i), vecs[i].bv, vecs[i].b0, vecs[i].b1, vecs[i].bl, vecs[i].wr);
      advance();
    end

    // Stall on the first byte while another word waits, then drain with a stall on the last byte
    drive(1, 0, 1, 32'hDDCCBBAA, 4'hF, 1);
    advance();
    for (int s = 0; s < 5; s++) begin
      drive(1, 0, 1, 32'h99999999, 4'hF, 0);
      expect_out($sformatf("stall%0d", s), 1, 8'hAA, 8'hDD, 0, 0);
      advance();
    end
    drive(1, 0, 0, 32'h0, 4'h0, 1);
    expect_out("rel_aa", 1, 8'hAA, 8'hDD, 0, 0);
    advance();
    expect_out("rel_bb", 1, 8'hBB, 8'hCC, 0, 0);
    advance();
    expect_out("rel_cc", 1, 8'hCC, 8'hBB, 0, 0);
    advance();
    drive(1, 0, 0, 32'h0, 4'h0, 0);
    expect_out("last_stall", 1, 8'hDD, 8'hAA, 1, 0);
    advance();
    drive(1, 0, 0, 32'h0, 4'h0, 1);
    expect_out("rel_dd", 1, 8'hDD, 8'hAA, 1, 1);
    advance();
    expect_out("drained", 0, 8'h00, 8'h00, 0, 1);

    // Flush mid-word: pass 0 uses sw_rst_i, pass 1 uses rst_ni
    for (int p = 0; p < 2; p++) begin
      drive(1, 0, 1, 32'hDDCCBBAA, 4'hF, 1);
      advance();
      drive(1, 0, 0, 32'h0, 4'h0, 1);
      expect_out($sformatf("fl%0d_aa", p), 1, 8'hAA, 8'hDD, 0, 0);
      advance();
      expect_out($sformatf("fl%0d_bb", p), 1, 8'hBB, 8'hCC, 0, 0);
      advance();
      if (p == 0) begin
        drive(1, 1, 1, 32'h99999999, 4'hF, 1);
        chk("sw_pulse.valid_le", {31'd0, byte_valid_le}, 32'd0);
        chk("sw_pulse.valid_be", {31'd0, byte_valid_be}, 32'd0);
        chk("sw_pulse.last_le",  {31'd0, byte_last_le},  32'd0);
        chk("sw_pulse.wready_le",{31'd0, word_ready_le}, 32'd0);
        chk("sw_pulse.wready_be",{31'd0, word_ready_be}, 32'd0);
      end else begin
        drive(0, 0, 1, 32'h99999999, 4'hF, 1);
      end
      advance();
      drive(1, 0, 0, 32'h0, 4'h0, 1);
      expect_out($sformatf("fl%0d_after", p), 0, 8'h00, 8'h00, 0, 1);
      advance();
      expect_out($sformatf("fl%0d_idle", p), 0, 8'h00, 8'h00, 0, 1);
      drive(1, 0, 1, 32'h000000A5, 4'h1, 1);
      expect_out($sformatf("fl%0d_load", p), 0, 8'h00, 8'h00, 0, 1);
      advance();
      drive(1, 0, 0, 32'h0, 4'h0, 1);
      expect_out($sformatf("fl%0d_a5", p), 1, 8'hA5, 8'hA5, 1, 1);
      advance();
      expect_out($sformatf("fl%0d_end", p), 0, 8'h00, 8'h00, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_host_byte_select.md
Name: spi_host_byte_select

Overview:
TX-path counterpart of the RX byte-merge stage in the SPI Host. Accepts 32-bit words with per-byte enables from the TX FIFO and emits only the enabled bytes, one per cycle, toward the shift-register/FSM byte interface. It holds one word internally. It sustains one byte per cycle across word boundaries with no bubble.

Parameters:
ByteOrder, 0, 0 = little-endian (lane 0 = word[7:0] first); 1 = big-endian (lane 3 = word[31:24] first).

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_ni  input  1  reset; synchronous and active-low
word_i  input  32  TX data word
word_be_i  input  4  byte enables; bit k qualifies word_i[8k+7:8k]
word_valid_i  input  1  word_i/word_be_i valid
word_ready_o  output  1  word accepted when word_valid_i & word_ready_o
byte_o  output  8  current byte
byte_valid_o  output  1  byte_o valid
byte_last_o  output  1  byte_o is the final enabled byte of its word
byte_ready_i  input  1  downstream consumes byte when byte_valid_i & byte_ready_i
sw_rst_i  input  1  software reset; flushes held word

Behaviour:
- State: word_q[31:0] and be_q[3:0]. be_q holds the remaining-enable mask. Buffer is empty iff be_q == 0.
- Reset (rst_ni low at posedge): word_q=0, be_q=0.
  - Outputs after reset: byte_valid_o=0, byte_last_o=0, byte_o=0, word_ready_o=1.
- Current lane:
  - ByteOrder=0: lowest set bit of be_q.
  - ByteOrder=1: highest set bit of be_q.
  - byte_o = word_q lane bits when be_q != 0, else 8'h00.
- byte_valid_o = (be_q != 0) & ~sw_rst_i.
- byte_last_o = byte_valid_o & (be_q has exactly one bit set).
- Byte handshake (byte_valid_o & byte_ready_i): the current lane bit is cleared in be_q next cycle. word_q is unchanged.
- word_ready_o = ~sw_rst_i & ((be_q == 0) | (byte_valid_o & byte_ready_i & byte_last_o)). This is combinational from byte_ready_i; no combinational path from word_valid_i.
- Word handshake: word_q <= word_i and be_q <= word_be_i. If it coincides with the last-byte handshake, the load wins.
- Latency: a word accepted at cycle N presents its first enabled byte at N+1.
  - Words are back-to-back; the last byte of word A at cycle M is followed by the first byte of word B at M+1.
- word_be_i = 4'b0000: the word is accepted and produces no bytes; word_ready_o stays 1.
- Non-contiguous enables (e.g. 4'b1010): only the enabled lanes are emitted, in lane order; gaps are skipped with no idle cycle.
- Stall: with byte_ready_i=0, byte_o, byte_valid_o and byte_last_o hold stable, and no word is accepted while be_q != 0.
- sw_rst_i high at a posedge: be_q <= 0 and word_q <= 0.
  - This takes priority over any handshake.
  - In the same cycle, word_ready_o=0 and byte_valid_o=0, so no transfer occurs.
- rst_ni low mid-word: state is cleared identically to sw_rst_i; the remaining bytes are discarded.

Test Plan:
- ByteOrder=0: word 32'hDDCCBBAA, be 4'hF, byte_ready_i=1 -> bytes AA,BB,CC,DD on cycles N+1..N+4; byte_last_o only with DD; word_ready_o=1 only on DD cycle.
- ByteOrder=1, same word -> DD,CC,BB,AA. be 4'b0101 with ByteOrder=0 -> AA then CC (last), no gap cycle.
- Two words 32'h44332211/4'hF then 32'h88776655/4'h3 held valid -> 11,22,33,44,55,66 on 6 consecutive cycles; byte_last_o on 44 and 66.
- be 4'h0 with word 32'h12345678 -> accepted in one cycle; byte_valid_o never asserts; following word 32'h000000EE/4'h1 -> EE at next cycle, byte_last_o=1.
- Stall: byte_ready_i low for 5 cycles after the first byte of 32'hDDCCBBAA -> byte_o=AA stable and word_ready_o=0 throughout; release -> remaining BB,CC,DD.
- sw_rst_i pulse after the second byte of a 4-byte word -> byte_valid_o=0 in the pulse cycle and after; next word 32'h000000A5/4'h1 -> only A5 emitted. Repeat with rst_ni low instead -> same result, all outputs at reset values.
